// File: rtl/uart_bist_controller_if.sv
// Handshake/status bundle between the UART loopback BIST sequencer and its
// environment (UART top strobes, signatures, start/result). The slave modport
// is the sequencer side; the master modport is whoever drives the run.
interface uart_bist_controller_if;
  logic        i_Start;
  logic [7:0]  i_Num_Bytes;
  logic        i_RX_DV;
  logic [15:0] i_SAR_Tx;
  logic [15:0] i_SAR_Rx;
  logic        o_Mode;
  logic        o_TX_DV;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Pass;
  logic [1:0]  o_Err_Code;
  logic [8:0]  o_Byte_Count;

  modport master (
    output i_Start, i_Num_Bytes, i_RX_DV, i_SAR_Tx, i_SAR_Rx,
    input  o_Mode, o_TX_DV, o_Busy, o_Done, o_Pass, o_Err_Code, o_Byte_Count
  );

  modport slave (
    input  i_Start, i_Num_Bytes, i_RX_DV, i_SAR_Tx, i_SAR_Rx,
    output o_Mode, o_TX_DV, o_Busy, o_Done, o_Pass, o_Err_Code, o_Byte_Count
  );
endinterface

// File: rtl/uart_bist_controller.sv
// UART loopback BIST sequencer: puts the UART top in LFSR mode, sends N bytes
// one at a time (each waiting for its loopback receive strobe, with timeout),
// then compares TX/RX signatures and reports pass/fail with an error code.
module uart_bist_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned GAP_CYCLES     = 256,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input logic                   i_Clock,
  input logic                   i_Rst,
  uart_bist_controller_if.slave bus
);

  localparam int unsigned CNT_MAX =
    (TIMEOUT_CYCLES > GAP_CYCLES)
      ? ((TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES)
      : ((GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES);
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Timeout compares one ahead of the incremented value so that o_Done rises
  // exactly TIMEOUT_CYCLES edges after the edge that raised o_TX_DV.
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_SPURIOUS = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SEND, S_WAIT_RX, S_GAP, S_SETTLE, S_CHECK, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       num_q, num_d;
  logic [8:0]       count_q, count_d;
  logic [8:0]       count_inc;
  logic [1:0]       err_q, err_d;
  logic             pass_q, pass_d;
  logic             mode_q, mode_d;
  logic             tx_dv_q, tx_dv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign count_inc = count_q + 9'd1;

  // Registered state, counters and all outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      count_q <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      mode_q  <= 1'b0;
      tx_dv_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      count_q <= count_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      mode_q  <= mode_d;
      tx_dv_q <= tx_dv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, run bookkeeping, and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    count_d = count_q;
    err_d   = err_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_Start) begin
          num_d   = (bus.i_Num_Bytes == 8'd0) ? 9'd256 : {1'b0, bus.i_Num_Bytes};
          count_d = '0;
          err_d   = ERR_NONE;
          pass_d  = 1'b0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.i_RX_DV && err_q == ERR_NONE) err_d = ERR_SPURIOUS;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.i_RX_DV && err_q == ERR_NONE) err_d = ERR_SPURIOUS;
        cnt_d   = '0;
        state_d = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        if (bus.i_RX_DV) begin
          count_d = count_inc;
          cnt_d   = '0;
          state_d = (count_inc == num_q) ? S_SETTLE : S_GAP;
        end else if (cnt_q == TO_LAST) begin
          if (err_q == ERR_NONE) err_d = ERR_TIMEOUT;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (bus.i_RX_DV && err_q == ERR_NONE) err_d = ERR_SPURIOUS;
        if (cnt_q == GAP_LAST) state_d = S_SEND;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      S_CHECK: begin
        if (err_q == ERR_NONE) begin
          if (bus.i_SAR_Tx == bus.i_SAR_Rx) pass_d = 1'b1;
          else                              err_d  = ERR_MISMATCH;
        end
        state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    tx_dv_d = (state_d == S_SEND);
    done_d  = (state_d == S_FINISH);
    busy_d  = (state_d != S_IDLE) && (state_d != S_FINISH);
    mode_d  = busy_d;
  end

  assign bus.o_Mode       = mode_q;
  assign bus.o_TX_DV      = tx_dv_q;
  assign bus.o_Busy       = busy_q;
  assign bus.o_Done       = done_q;
  assign bus.o_Pass       = pass_q;
  assign bus.o_Err_Code   = err_q;
  assign bus.o_Byte_Count = count_q;

endmodule

// File: tb/tb_uart_bist_controller.sv
// Bench for uart_bist_controller: a loopback responder echoes each o_TX_DV as
// an i_RX_DV after a latency, directed vectors and randomized runs are checked
// against expected results and cycle timing derived from the block's rules.
module tb_uart_bist_controller;
  localparam int unsigned TO = 64;
  localparam int unsigned GP = 8;
  localparam int unsigned ST = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  uart_bist_controller_if bus();

  uart_bist_controller #(
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GP),
    .SETTLE_CYCLES (ST)
  ) dut (
    .i_Clock(clk),
    .i_Rst  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // Loopback responder / monitor state
  bit   lb_en       = 1'b0;
  int   drop_from   = 0;
  int   lat_fixed   = 0;
  bit   spur_arm    = 1'b0;
  bit   idle_rx_req = 1'b0;
  int   rx_timer    = 0;
  int   spur_at     = -1;
  int   tx_log[$];
  int   rx_log[$];
  int   tx_bad      = 0;
  int   done_seen   = 0;
  int   done_cyc    = 0;
  int   done_flags  = 0;

  typedef struct {
    string       name;
    int          n;
    int          drop;
    bit          spur;
    logic [15:0] stx;
    logic [15:0] srx;
    bit          busy_start;
    int          lat;
    int          exp_count;
    logic [1:0]  exp_err;
    bit          exp_pass;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: the result of a run from counts of delivered bytes and events.
  function automatic void model(input int n, input int drop, input bit spur, input bit eq,
                                output int cnt, output logic [1:0] err, output bit pass);
    int  nn;
    bit  timed_out;
    nn        = (n == 0) ? 256 : n;
    timed_out = (drop != 0) && (drop <= nn);
    cnt       = timed_out ? drop - 1 : nn;
    if (spur && cnt >= 1 && nn >= 2) err = 2'b11;
    else if (timed_out)              err = 2'b01;
    else if (!eq)                    err = 2'b10;
    else                             err = 2'b00;
    pass = (err == 2'b00);
  endfunction

  // Loopback: drive i_RX_DV after posedge, observe outputs on negedge.
  initial begin
    bus.i_RX_DV = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.i_RX_DV = 1'b0;
      if (rx_timer > 0) begin
        rx_timer--;
        if (rx_timer == 0) begin
          bus.i_RX_DV = 1'b1;
          rx_log.push_back(cyc);
          if (spur_arm && rx_log.size() == 1) spur_at = cyc + 3;
        end
      end
      if (spur_at >= 0 && cyc == spur_at) begin
        bus.i_RX_DV = 1'b1;
        spur_at     = -1;
      end
      if (idle_rx_req) begin
        bus.i_RX_DV = 1'b1;
        idle_rx_req = 1'b0;
      end
      @(negedge clk);
      if (bus.o_TX_DV) begin
        tx_log.push_back(cyc);
        if (!bus.o_Busy || !bus.o_Mode) tx_bad++;
        if (lb_en && (drop_from == 0 || tx_log.size() < drop_from))
          rx_timer = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 8));
      end
      if (bus.o_Done) begin
        done_seen++;
        done_cyc   = cyc;
        done_flags = int'({bus.o_Busy, bus.o_Mode});
      end
    end
  end

  task automatic run(input string nm, input int n, input int drop, input bit spur,
                     input logic [15:0] stx, input logic [15:0] srx, input bit busy_start,
                     input int lat, input int exp_count, input logic [1:0] exp_err,
                     input bit exp_pass);
    int nn, st, budget, k, bad, exp_ntx, act;
    nn = (n == 0) ? 256 : n;
    tx_log.delete();
    rx_log.delete();
    tx_bad    = 0;
    done_seen = 0;
    drop_from = drop;
    spur_arm  = spur;
    lat_fixed = lat;
    lb_en     = 1'b1;
    bus.i_SAR_Tx = stx;
    bus.i_SAR_Rx = srx;
    @(posedge clk); #1;
    bus.i_Num_Bytes = 8'(n);
    bus.i_Start     = 1'b1;
    st = cyc;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    if (busy_start) begin
      repeat (3) @(posedge clk);
      #1;
      bus.i_Num_Bytes = 8'(n + 3);
      bus.i_Start     = 1'b1;
      @(posedge clk); #1;
      bus.i_Start = 1'b0;
    end
    budget = nn * (GP + TO + 4) + TO + 100;
    k = 0;
    while (done_seen == 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (4) @(negedge clk);
    #1;
    check({nm, ":done_pulses"}, done_seen, 1);
    check({nm, ":count"}, int'(bus.o_Byte_Count), exp_count);
    check({nm, ":err"}, int'(bus.o_Err_Code), int'(exp_err));
    check({nm, ":pass"}, int'(bus.o_Pass), int'(exp_pass));
    check({nm, ":busy_mode_at_done"}, done_flags, 0);
    exp_ntx = exp_count + ((exp_err == 2'b01) ? 1 : 0);
    check({nm, ":tx_pulses"}, tx_log.size(), exp_ntx);
    check({nm, ":first_tx_lat"}, (tx_log.size() > 0) ? tx_log[0] - st : -1, 2);
    bad = tx_bad;
    for (int i = 0; i < rx_log.size(); i++)
      if (i + 1 < tx_log.size() && tx_log[i+1] - rx_log[i] != int'(GP) + 1) bad++;
    check({nm, ":tx_spacing"}, bad, 0);
    if (exp_err == 2'b01) begin
      act = (tx_log.size() > 0) ? done_cyc - tx_log[tx_log.size()-1] : -1;
      check({nm, ":done_after_tx"}, act, int'(TO));
    end else begin
      act = (rx_log.size() > 0) ? done_cyc - rx_log[rx_log.size()-1] : -1;
      check({nm, ":done_after_rx"}, act, int'(ST) + 2);
    end
    lb_en    = 1'b0;
    spur_arm = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int          k, rc, rn, rd;
    logic [1:0]  re;
    bit          rp, rs, req;
    logic [15:0] rtx;

    rst             = 1'b1;
    bus.i_Start     = 1'b0;
    bus.i_Num_Bytes = 8'd0;
    bus.i_SAR_Tx    = 16'h0;
    bus.i_SAR_Rx    = 16'h0;

    vt[0]  = '{"happy4",        4, 0, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0, 0,      4, 2'b00, 1'b1};
    vt[1]  = '{"timeout3",      3, 2, 1'b0, 16'h1111, 16'h1111, 1'b0, 0,      1, 2'b01, 1'b0};
    vt[2]  = '{"mismatch2",     2, 0, 1'b0, 16'hBEEF, 16'hDEAD, 1'b0, 0,      2, 2'b10, 1'b0};
    vt[3]  = '{"spur_gap3",     3, 0, 1'b1, 16'h2222, 16'h2222, 1'b0, 0,      3, 2'b11, 1'b0};
    vt[4]  = '{"spur_and_mis",  2, 0, 1'b1, 16'hBEEF, 16'hDEAD, 1'b0, 0,      2, 2'b11, 1'b0};
    vt[5]  = '{"start_busy",    5, 0, 1'b0, 16'h3333, 16'h3333, 1'b1, 0,      5, 2'b00, 1'b1};
    vt[6]  = '{"single",        1, 0, 1'b0, 16'h4444, 16'h4444, 1'b0, 0,      1, 2'b00, 1'b1};
    vt[7]  = '{"timeout_first", 5, 1, 1'b0, 16'h5555, 16'h5555, 1'b0, 0,      0, 2'b01, 1'b0};
    vt[8]  = '{"rx_terminal",   2, 0, 1'b0, 16'h6666, 16'h6666, 1'b0, TO - 1, 2, 2'b00, 1'b1};
    vt[9]  = '{"rx_too_late",   1, 0, 1'b0, 16'h7777, 16'h7777, 1'b0, TO,     0, 2'b01, 1'b0};
    vt[10] = '{"n0_is_256",     0, 0, 1'b0, 16'h8888, 16'h8888, 1'b0, 0,    256, 2'b00, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({bus.o_Mode, bus.o_TX_DV, bus.o_Busy, bus.o_Done,
                                 bus.o_Pass, bus.o_Err_Code, bus.o_Byte_Count}), 0);
    rst = 1'b0;
    idle_rx_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_rx_ignored", int'({bus.o_Mode, bus.o_TX_DV, bus.o_Busy, bus.o_Done,
                                   bus.o_Pass, bus.o_Err_Code, bus.o_Byte_Count}), 0);

    for (int i = 0; i < 11; i++)
      run(vt[i].name, vt[i].n, vt[i].drop, vt[i].spur, vt[i].stx, vt[i].srx,
          vt[i].busy_start, vt[i].lat, vt[i].exp_count, vt[i].exp_err, vt[i].exp_pass);

    // Reset during WAIT_RX of byte 2: outputs clear at that edge, no o_Done follows.
    tx_log.delete();
    rx_log.delete();
    done_seen = 0;
    drop_from = 0;
    lat_fixed = 6;
    lb_en     = 1'b1;
    @(posedge clk); #1;
    bus.i_Num_Bytes = 8'd3;
    bus.i_Start     = 1'b1;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    k = 0;
    while (tx_log.size() < 2 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    check("rst_mid:second_tx_seen", tx_log.size(), 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid:outputs", int'({bus.o_Mode, bus.o_TX_DV, bus.o_Busy, bus.o_Done,
                                   bus.o_Pass, bus.o_Err_Code, bus.o_Byte_Count}), 0);
    lb_en = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("rst_mid:no_done", done_seen, 0);
    run("after_rst", 3, 0, 1'b0, 16'h9999, 16'h9999, 1'b0, 0, 3, 2'b00, 1'b1);

    // Randomized runs against the reference model.
    for (int r = 0; r < 12; r++) begin
      rn  = int'($urandom_range(1, 12));
      rd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rn)) : 0;
      rs  = (rd == 0) && (rn >= 2) && ($urandom_range(0, 2) == 0);
      req = ($urandom_range(0, 2) != 0);
      rtx = 16'($urandom);
      model(rn, rd, rs, req, rc, re, rp);
      run($sformatf("rnd%0d", r), rn, rd, rs, rtx, req ? rtx : (rtx ^ 16'h0101),
          1'b0, 0, rc, re, rp);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, total);
    $fatal(1);
  end

endmodule
